vga_pattern_gen: RTL and testbench
==================================

Name: vga_pattern_gen

Overview:
- Upstream pixel source for vga_if. Replaces the constant RGB tie-off in vga_top with a selectable test pattern.
- Runs on the pixel clock (vgaClkW domain).
- Keeps its own horizontal/vertical position counters, started by the same reset as vga_if, so it knows which pixel vga_if is consuming.
- Produces registered 4:4:4 RGB, plus an active-video flag and a frame-start pulse for debug and alignment.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_TOTAL, 800, pixel clocks per line including blanking
- V_ACTIVE, 480, visible lines per frame
- V_TOTAL, 525, lines per frame including blanking
- LEAD, 1, counter lead in clocks; compensates vga_if input-register latency (range 0..H_TOTAL-1)
- BOX_SIZE, 32, bouncing-box edge length in pixels
- CHECK_LOG2, 5, checkerboard square size = 2**CHECK_LOG2 pixels

Ports:
- clkIn  input  1  pixel clock
- rstIn  input  1  asynchronous, active-low reset
- modeIn  input  2  pattern select: 0 solid, 1 colour bars, 2 checkerboard, 3 bouncing box
- colourIn  input  12  {R,G,B} nibbles; used by solid and box modes
- vgaROut  output  4  red to vga_if vgaRIn
- vgaGOut  output  4  green to vga_if vgaGIn
- vgaBOut  output  4  blue to vga_if vgaBIn
- activeOut  output  1  registered: output pixel is in the visible area
- frameStartOut  output  1  one-cycle pulse, coincident with output of pixel (0,0)

Behaviour:
- Reset (rstIn=0, async):
  - All outputs 0.
  - hCnt=LEAD, vCnt=0, modeReg=0, colourReg=0.
  - boxX=0, boxY=0, dirX=+1, dirY=+1, frameCnt=0, bar counters 0.
- Counters:
  - hCnt increments 0..H_TOTAL-1, then wraps to 0.
  - vCnt increments when hCnt wraps, 0..V_TOTAL-1, then wraps to 0.
- Latency: outputs are registered, so each output reflects the counter value of the previous cycle. The first post-reset output cycle shows pixel index LEAD.
- Blanking: when hCnt>=H_ACTIVE or vCnt>=V_ACTIVE, the registered RGB is 0 and activeOut is 0.
- Frame start (hCnt=0, vCnt=0):
  - Latch modeIn into modeReg and colourIn into colourReg. Changes mid-frame take effect on the next frame only (no tearing).
  - Increment frameCnt (8 bit, wraps).
  - Step the box.
- Solid mode: every active pixel = colourReg.
- Colour bars:
  - 8 bars, each H_ACTIVE/8 pixels wide, in order white FFF, yellow FF0, cyan 0FF, green 0F0, magenta F0F, red F00, blue 00F, black 000.
  - Bar index comes from a width counter plus a 3-bit index counter, both cleared at hCnt=0. No divider.
- Checkerboard: pixel is white FFF if hCnt[CHECK_LOG2] XOR vCnt[CHECK_LOG2] = 1, else black 000.
- Box mode:
  - Pixel = colourReg when boxX<=h<boxX+BOX_SIZE and boxY<=v<boxY+BOX_SIZE, else 000.
  - At each frame start, boxX += dirX and boxY += dirY.
  - dirX flips when boxX reaches 0 or H_ACTIVE-BOX_SIZE; dirY likewise against V_ACTIVE-BOX_SIZE. The box never leaves the visible area.
  - Position and direction update in all modes, so the box keeps moving while not displayed.
- Mode change and frame start in the same cycle: the new mode applies to pixel (0,0).
- Reset mid-frame: outputs go to 0 immediately; counters restart at hCnt=LEAD, vCnt=0, exactly as after power-up.
- Widths: hCnt and vCnt are clog2(H_TOTAL) and clog2(V_TOTAL) bits wide; comparisons are unsigned.

Optional Feature:
- Macro: VGA_PATTERN_BORDER_EN.
- Defined: active pixels with h=0, h=H_ACTIVE-1, v=0 or v=V_ACTIVE-1 output white FFF, overriding every mode. Used for monitor framing checks.
- Undefined: no border logic; the pattern covers the full active area.

Decomposition:
- Package vga_timing_pkg holds:
  - H_ACTIVE/H_TOTAL/V_ACTIVE/V_TOTAL defaults, shared with vga_if.
  - Mode codes MODE_SOLID/MODE_BARS/MODE_CHECK/MODE_BOX.
  - 12-bit colour constants.
- Sub-module vga_pixel_counter: h/v counters with reset preload, frame-start flag and active flag. vga_pattern_gen instantiates one.

Test Plan:
- Hold rstIn=0 for 5 clocks -> all outputs 0; release -> first output pixel index = LEAD; frameStartOut pulses once every 420000 clocks.
- Mode 0, colourIn=F00 -> active pixels R=F G=0 B=0; pixels h=640..799 and lines 480..524 give RGB=0 and activeOut=0.
- Mode 1 -> line 0: h=0 gives FFF, h=80 gives FF0, h=400 gives F00, h=639 gives 000.
- Switch modeIn 0->2 at line 200 -> rest of the current frame stays solid; next frame: pixel (32,0)=FFF, (0,0)=000, (32,32)=000.
- Mode 3, BOX_SIZE=32 -> after 608 frames boxX=608; the next frame boxX=607 and dirX is reversed; boxY reverses at 448.
- Assert rstIn mid-line at h=300 -> outputs 0 asynchronously; after release, counters restart at hCnt=LEAD and the box returns to (0,0).

Source files
------------

// File: rtl/vga_timing_pkg.sv
// VGA timing defaults, pattern mode codes and colour constants
// shared by vga_if and the pattern generator.
package vga_timing_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_TOTAL  = 800;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_TOTAL  = 525;

    typedef enum logic [1:0] {
        MODE_SOLID = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_CHECK = 2'd2,
        MODE_BOX   = 2'd3
    } mode_t;

    localparam logic [11:0] C_WHITE   = 12'hFFF;
    localparam logic [11:0] C_YELLOW  = 12'hFF0;
    localparam logic [11:0] C_CYAN    = 12'h0FF;
    localparam logic [11:0] C_GREEN   = 12'h0F0;
    localparam logic [11:0] C_MAGENTA = 12'hF0F;
    localparam logic [11:0] C_RED     = 12'hF00;
    localparam logic [11:0] C_BLUE    = 12'h00F;
    localparam logic [11:0] C_BLACK   = 12'h000;

    function automatic logic [11:0] barColour(input logic [2:0] idx);
        logic [11:0] c;
        c = C_BLACK;
        unique case (idx)
            3'd0: c = C_WHITE;
            3'd1: c = C_YELLOW;
            3'd2: c = C_CYAN;
            3'd3: c = C_GREEN;
            3'd4: c = C_MAGENTA;
            3'd5: c = C_RED;
            3'd6: c = C_BLUE;
            3'd7: c = C_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_pixel_counter.sv
// Horizontal/vertical raster counters preloaded LEAD pixels ahead
// so the generator stays aligned with the registered vga_if input.
module vga_pixel_counter
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_TOTAL  = VGA_H_TOTAL,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_TOTAL  = VGA_V_TOTAL,
    parameter int LEAD     = 1
) (
    input  logic                       clkIn,
    input  logic                       rstIn,
    output logic [$clog2(H_TOTAL)-1:0] hCnt,
    output logic [$clog2(V_TOTAL)-1:0] vCnt,
    output logic                       lineEnd,
    output logic                       frameStart,
    output logic                       active
);

    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);

    assign lineEnd    = (hCnt == H_LAST);
    assign frameStart = (hCnt == '0) && (vCnt == '0);
    assign active     = (hCnt < H_ACT) && (vCnt < V_ACT);

    always_ff @(posedge clkIn or negedge rstIn) begin
        if (!rstIn) begin
            hCnt <= HW'(LEAD);
            vCnt <= '0;
        end else if (lineEnd) begin
            hCnt <= '0;
            vCnt <= (vCnt == V_LAST) ? '0 : vCnt + VW'(1);
        end else begin
            hCnt <= hCnt + HW'(1);
        end
    end

endmodule

// File: rtl/vga_pattern_gen.sv
// Selectable VGA test pattern source feeding vga_if.
// Define VGA_PATTERN_BORDER_EN to draw a white frame on the active edge.
module vga_pattern_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE   = VGA_H_ACTIVE,
    parameter int H_TOTAL    = VGA_H_TOTAL,
    parameter int V_ACTIVE   = VGA_V_ACTIVE,
    parameter int V_TOTAL    = VGA_V_TOTAL,
    parameter int LEAD       = 1,
    parameter int BOX_SIZE   = 32,
    parameter int CHECK_LOG2 = 5
) (
    input  logic        clkIn,
    input  logic        rstIn,
    input  logic [1:0]  modeIn,
    input  logic [11:0] colourIn,
    output logic [3:0]  vgaROut,
    output logic [3:0]  vgaGOut,
    output logic [3:0]  vgaBOut,
    output logic        activeOut,
    output logic        frameStartOut
);

    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);

    localparam logic [HW-1:0] X_MAX    = HW'(H_ACTIVE - BOX_SIZE);
    localparam logic [VW-1:0] Y_MAX    = VW'(V_ACTIVE - BOX_SIZE);
    localparam logic [HW-1:0] BOX_H    = HW'(BOX_SIZE);
    localparam logic [VW-1:0] BOX_V    = VW'(BOX_SIZE);
    localparam logic [HW-1:0] BAR_LAST = HW'(H_ACTIVE / 8 - 1);

    logic [HW-1:0] hCnt;
    logic [VW-1:0] vCnt;
    logic          lineEnd;
    logic          frameStart;
    logic          active;

    mode_t         modeReg;
    mode_t         modeNow;
    logic [11:0]   colourReg;
    logic [11:0]   colourNow;
    logic [7:0]    frameCnt;

    logic [HW-1:0] boxX;
    logic [HW-1:0] boxXNext;
    logic [HW-1:0] boxXNow;
    logic [VW-1:0] boxY;
    logic [VW-1:0] boxYNext;
    logic [VW-1:0] boxYNow;
    logic          dirX;
    logic          dirXNext;
    logic          dirY;
    logic          dirYNext;
    logic          inBox;

    logic [HW-1:0] barCnt;
    logic [2:0]    barIdx;
    logic          border;
    logic [11:0]   pix;

    vga_pixel_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_TOTAL  (H_TOTAL),
        .V_ACTIVE (V_ACTIVE),
        .V_TOTAL  (V_TOTAL),
        .LEAD     (LEAD)
    ) uCounter (
        .clkIn      (clkIn),
        .rstIn      (rstIn),
        .hCnt       (hCnt),
        .vCnt       (vCnt),
        .lineEnd    (lineEnd),
        .frameStart (frameStart),
        .active     (active)
    );

`ifdef VGA_PATTERN_BORDER_EN
    localparam logic [HW-1:0] H_EDGE = HW'(H_ACTIVE - 1);
    localparam logic [VW-1:0] V_EDGE = VW'(V_ACTIVE - 1);

    assign border = active &&
        (hCnt == '0 || hCnt == H_EDGE ||
         vCnt == '0 || vCnt == V_EDGE);
`else
    assign border = 1'b0;
`endif

    // Pixel (0,0) already sees the settings being latched this cycle.
    always_comb begin
        modeNow   = frameStart ? mode_t'(modeIn) : modeReg;
        colourNow = frameStart ? colourIn : colourReg;

        boxXNext = dirX ? boxX + HW'(1) : boxX - HW'(1);
        boxYNext = dirY ? boxY + VW'(1) : boxY - VW'(1);

        dirXNext = dirX;
        if (boxXNext == X_MAX) dirXNext = 1'b0;
        else if (boxXNext == '0) dirXNext = 1'b1;

        dirYNext = dirY;
        if (boxYNext == Y_MAX) dirYNext = 1'b0;
        else if (boxYNext == '0) dirYNext = 1'b1;

        boxXNow = frameStart ? boxXNext : boxX;
        boxYNow = frameStart ? boxYNext : boxY;

        inBox = (hCnt >= boxXNow) && (hCnt < boxXNow + BOX_H) &&
                (vCnt >= boxYNow) && (vCnt < boxYNow + BOX_V);

        pix = C_BLACK;
        if (active) begin
            unique case (modeNow)
                MODE_SOLID: pix = colourNow;
                MODE_BARS:  pix = barColour(barIdx);
                MODE_CHECK: pix = (hCnt[CHECK_LOG2] ^ vCnt[CHECK_LOG2])
                                  ? C_WHITE : C_BLACK;
                MODE_BOX:   pix = inBox ? colourNow : C_BLACK;
            endcase
        end
        if (border) pix = C_WHITE;
    end

    always_ff @(posedge clkIn or negedge rstIn) begin
        if (!rstIn) begin
            vgaROut       <= '0;
            vgaGOut       <= '0;
            vgaBOut       <= '0;
            activeOut     <= 1'b0;
            frameStartOut <= 1'b0;
            modeReg       <= MODE_SOLID;
            colourReg     <= '0;
            frameCnt      <= '0;
            boxX          <= '0;
            boxY          <= '0;
            dirX          <= 1'b1;
            dirY          <= 1'b1;
            barCnt        <= '0;
            barIdx        <= '0;
        end else begin
            {vgaROut, vgaGOut, vgaBOut} <= pix;
            activeOut     <= active;
            frameStartOut <= frameStart;

            if (frameStart) begin
                modeReg   <= mode_t'(modeIn);
                colourReg <= colourIn;
                frameCnt  <= frameCnt + 8'd1;
                boxX      <= boxXNext;
                boxY      <= boxYNext;
                dirX      <= dirXNext;
                dirY      <= dirYNext;
            end

            // Bar counters track the pixel at the current hCnt.
            if (lineEnd) begin
                barCnt <= '0;
                barIdx <= '0;
            end else if (barCnt == BAR_LAST) begin
                barCnt <= '0;
                barIdx <= barIdx + 3'd1;
            end else begin
                barCnt <= barCnt + HW'(1);
            end
        end
    end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench for vga_pattern_gen on a reduced 20x10 raster.
module tb_vga_pattern_gen;

    localparam int H_ACTIVE   = 16;
    localparam int H_TOTAL    = 20;
    localparam int V_ACTIVE   = 8;
    localparam int V_TOTAL    = 10;
    localparam int LEAD       = 3;
    localparam int BOX_SIZE   = 4;
    localparam int CHECK_LOG2 = 1;
    localparam int FRAME      = H_TOTAL * V_TOTAL;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [11:0] colour = 12'hF00;
    logic [3:0]  r;
    logic [3:0]  g;
    logic [3:0]  b;
    logic        act;
    logic        fs;
    logic [13:0] obs;

    int nAsserts = 0;
    int nFails = 0;
    int bh = 0;
    int bv = 0;
    bit shown = 1'b0;
    int n;

    always #5 clk = ~clk;

    assign obs = {fs, act, r, g, b};

    vga_pattern_gen #(
        .H_ACTIVE   (H_ACTIVE),
        .H_TOTAL    (H_TOTAL),
        .V_ACTIVE   (V_ACTIVE),
        .V_TOTAL    (V_TOTAL),
        .LEAD       (LEAD),
        .BOX_SIZE   (BOX_SIZE),
        .CHECK_LOG2 (CHECK_LOG2)
    ) dut (
        .clkIn         (clk),
        .rstIn         (rstN),
        .modeIn        (mode),
        .colourIn      (colour),
        .vgaROut       (r),
        .vgaGOut       (g),
        .vgaBOut       (b),
        .activeOut     (act),
        .frameStartOut (fs)
    );

    function automatic logic [13:0] ex(input logic f, input logic a,
                                       input logic [11:0] c);
        return {f, a, c};
    endfunction

    task automatic chk(input string tag, input logic [13:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chkInt(input string tag, input int got, input int exp);
        nAsserts++;
        assert (got === exp) else begin
            nFails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Bench-side raster model: pixel currently shown at the outputs.
    task automatic step();
        @(posedge clk);
        #1;
        if (!shown) begin
            bh = LEAD;
            bv = 0;
            shown = 1'b1;
        end else begin
            bh++;
            if (bh == H_TOTAL) begin
                bh = 0;
                bv++;
                if (bv == V_TOTAL) bv = 0;
            end
        end
    endtask

    task automatic gotoPix(input int h, input int v);
        int k;
        k = 0;
        while (!(shown && bh == h && bv == v) && k < 2 * FRAME) begin
            step();
            k++;
        end
        if (!(shown && bh == h && bv == v)) begin
            nAsserts++;
            nFails++;
            $error("FAIL goto(%0d,%0d): not reached in %0d clocks", h, v, k);
        end
    endtask

    task automatic nextFrame();
        step();
        gotoPix(0, 0);
    endtask

    task automatic countFs(output int k);
        k = 0;
        do begin
            step();
            k++;
        end while (!fs && k < 2 * FRAME);
    endtask

    initial begin
        repeat (5) @(posedge clk);
        #1;
        chk("reset", ex(0, 0, 12'h000));
        rstN = 1'b1;

        step();
        chk("firstPix", ex(0, 1, 12'h000));
        countFs(n);
        chkInt("leadToFrame", n, FRAME - LEAD);
        chk("f1Origin", ex(1, 1, 12'hF00));
        countFs(n);
        chkInt("framePeriod", n, FRAME);

        gotoPix(15, 0); chk("solidEdge", ex(0, 1, 12'hF00));
        gotoPix(16, 0); chk("hBlank", ex(0, 0, 12'h000));
        gotoPix(19, 3); chk("hBlankEnd", ex(0, 0, 12'h000));
        gotoPix(5, 8);  chk("vBlank", ex(0, 0, 12'h000));
        mode = 2'd1;

        gotoPix(0, 0);  chk("bar0", ex(1, 1, 12'hFFF));
        gotoPix(2, 0);  chk("bar1", ex(0, 1, 12'hFF0));
        gotoPix(10, 0); chk("bar5", ex(0, 1, 12'hF00));
        gotoPix(15, 0); chk("bar7", ex(0, 1, 12'h000));
        gotoPix(0, 4);
        mode = 2'd0;
        colour = 12'h0F0;
        gotoPix(5, 4);  chk("noTear", ex(0, 1, 12'h0FF));

        gotoPix(0, 0);  chk("solidG", ex(1, 1, 12'h0F0));
        gotoPix(0, 4);
        mode = 2'd2;
        gotoPix(7, 7);  chk("stillSolid", ex(0, 1, 12'h0F0));

        gotoPix(0, 0);  chk("chk00", ex(1, 1, 12'h000));
        gotoPix(2, 0);  chk("chk20", ex(0, 1, 12'hFFF));
        gotoPix(3, 1);  chk("chk31", ex(0, 1, 12'hFFF));
        gotoPix(0, 2);  chk("chk02", ex(0, 1, 12'hFFF));
        gotoPix(2, 2);  chk("chk22", ex(0, 1, 12'h000));

        gotoPix(19, 9);
        mode = 2'd0;
        colour = 12'h00F;
        step();         chk("sameCycle", ex(1, 1, 12'h00F));
        gotoPix(1, 0);
        mode = 2'd3;
        colour = 12'hF0F;
        gotoPix(5, 0);  chk("colourHold", ex(0, 1, 12'h00F));

        gotoPix(0, 0);  chk("boxOrigin", ex(1, 1, 12'h000));
        gotoPix(6, 1);  chk("boxLeft", ex(0, 1, 12'h000));
        gotoPix(7, 1);  chk("boxTL", ex(0, 1, 12'hF0F));
        gotoPix(11, 1); chk("boxRight", ex(0, 1, 12'h000));
        gotoPix(10, 4); chk("boxBR", ex(0, 1, 12'hF0F));
        gotoPix(7, 5);  chk("boxBelow", ex(0, 1, 12'h000));

        repeat (5) nextFrame();
        gotoPix(12, 3); chk("xMaxAbove", ex(0, 1, 12'h000));
        gotoPix(11, 4); chk("xMaxLeft", ex(0, 1, 12'h000));
        gotoPix(12, 4); chk("xMax", ex(0, 1, 12'hF0F));
        gotoPix(15, 7); chk("xMaxBR", ex(0, 1, 12'hF0F));

        nextFrame();
        gotoPix(11, 2); chk("revAbove", ex(0, 1, 12'h000));
        gotoPix(11, 3); chk("revX", ex(0, 1, 12'hF0F));
        gotoPix(15, 3); chk("revRight", ex(0, 1, 12'h000));
        gotoPix(14, 6); chk("revBR", ex(0, 1, 12'hF0F));

        #2 rstN = 1'b0;
        #1 chk("asyncRst", ex(0, 0, 12'h000));
        repeat (2) @(posedge clk);
        #1;
        rstN = 1'b1;
        shown = 1'b0;

        step();
        chk("rstFirstPix", ex(0, 1, 12'h000));
        countFs(n);
        chkInt("rstLead", n, FRAME - LEAD);
        chk("rstOrigin", ex(1, 1, 12'h000));
        gotoPix(1, 0);  chk("rstAbove", ex(0, 1, 12'h000));
        gotoPix(0, 1);  chk("rstLeft", ex(0, 1, 12'h000));
        gotoPix(1, 1);  chk("rstBox", ex(0, 1, 12'hF0F));
        gotoPix(4, 4);  chk("rstBoxBR", ex(0, 1, 12'hF0F));
        gotoPix(5, 4);  chk("rstRight", ex(0, 1, 12'h000));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nAsserts, nFails);
        $finish;
    end

endmodule
